// File: rtl/led_pkg.sv
// Shared types and helpers for the LED sequencer.
//   mode_e  : running-light modes selectable over the config port
//   state_e : sequencer FSM states
//   start_pattern() : pattern loaded when a config is accepted
package led_pkg;

  localparam int unsigned MAX_LED = 32;

  typedef enum logic [1:0] {
    SHIFT_L  = 2'd0,
    SHIFT_R  = 2'd1,
    PINGPONG = 2'd2,
    FILL     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Start pattern, LSB-aligned; callers truncate to their LED count.
  function automatic logic [MAX_LED-1:0] start_pattern(input mode_e mode,
                                                       input int unsigned n_led);
    if (mode == SHIFT_R) begin
      return MAX_LED'(1) << (n_led - 1);
    end
    return MAX_LED'(1);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-step prescaler.
//   clk, rstn : clock, async active-low reset
//   en        : count enable
//   clr       : synchronous clear (wins over counting)
//   tc        : terminal count, high while enabled and counter == TICK_DIV-1
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 6_750_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = en && (cnt_q == LAST);

  // Free-running 0..TICK_DIV-1 while enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr || tc) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: steps an N_LED pattern through one of four
// running-light modes at a prescaled tick rate.
//   clk, rstn         : clock, async active-low reset
//   cfg_valid/ready   : config handshake (transfer on valid && ready)
//   cfg_mode, cfg_run : mode select and run/hold bit
//   led_o             : registered LED drive (polarity per ACTIVE_LOW)
//   tick_o            : one-cycle pulse with each advanced pattern
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int unsigned N_LED      = 6,
  parameter int unsigned TICK_DIV   = 6_750_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_run,
  output logic [N_LED-1:0] led_o,
  output logic             tick_o
);

  localparam logic [N_LED-1:0] LED_OFF = ACTIVE_LOW ? {N_LED{1'b1}} : {N_LED{1'b0}};

  state_e           state_q, state_nxt;
  mode_e            mode_q, mode_nxt;
  logic             run_q, run_nxt;
  logic [N_LED-1:0] pattern_q, pattern_nxt;
  logic             dir_up_q, dir_up_nxt;
  logic             ready_q, tick_q;
  logic [N_LED-1:0] led_q;

  logic             accept;
  logic             tc;
  logic             step;
  logic [N_LED-1:0] adv_pattern;
  logic             adv_dir_up;

  assign accept    = cfg_valid && ready_q;
  assign cfg_ready = ready_q;
  assign tick_o    = tick_q;
  assign led_o     = led_q;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .en   (state_q == RUN),
    .clr  (accept || (state_q != RUN)),
    .tc   (tc)
  );

  // Next pattern and pingpong direction for the current mode.
  always_comb begin
    adv_pattern = pattern_q;
    adv_dir_up  = dir_up_q;
    unique case (mode_q)
      SHIFT_L: adv_pattern = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
      SHIFT_R: adv_pattern = {pattern_q[0], pattern_q[N_LED-1:1]};
      PINGPONG: begin
        adv_pattern = dir_up_q ? (pattern_q << 1) : (pattern_q >> 1);
        // Flip as soon as the lit bit lands on an end so ends are not repeated.
        if (adv_pattern[N_LED-1]) begin
          adv_dir_up = 1'b0;
        end else if (adv_pattern[0]) begin
          adv_dir_up = 1'b1;
        end
      end
      FILL: adv_pattern = (&pattern_q) ? '0 : {pattern_q[N_LED-2:0], 1'b1};
      default: adv_pattern = pattern_q;
    endcase
  end

  // Sequencer FSM: next state, latched config and pattern update.
  always_comb begin
    state_nxt   = state_q;
    mode_nxt    = mode_q;
    run_nxt     = run_q;
    pattern_nxt = pattern_q;
    dir_up_nxt  = dir_up_q;
    step        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_nxt  = mode_e'(cfg_mode);
          run_nxt   = cfg_run;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        pattern_nxt = N_LED'(start_pattern(mode_q, N_LED));
        dir_up_nxt  = 1'b1;
        state_nxt   = run_q ? RUN : IDLE;
      end
      RUN: begin
        // A config accepted on the terminal-count cycle suppresses the step.
        if (accept) begin
          mode_nxt  = mode_e'(cfg_mode);
          run_nxt   = cfg_run;
          state_nxt = LOAD;
        end else if (tc) begin
          pattern_nxt = adv_pattern;
          dir_up_nxt  = adv_dir_up;
          step        = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      mode_q    <= SHIFT_L;
      run_q     <= 1'b0;
      pattern_q <= '0;
      dir_up_q  <= 1'b1;
      ready_q   <= 1'b1;
      tick_q    <= 1'b0;
      led_q     <= LED_OFF;
    end else begin
      state_q   <= state_nxt;
      mode_q    <= mode_nxt;
      run_q     <= run_nxt;
      pattern_q <= pattern_nxt;
      dir_up_q  <= dir_up_nxt;
      ready_q   <= (state_nxt != LOAD);
      tick_q    <= step;
      led_q     <= ACTIVE_LOW ? ~pattern_nxt : pattern_nxt;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized bench for led_seq_ctrl against a timeline reference model:
// expected LEDs are derived from the step count since the last accept.
module tb_led_seq_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned TD = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [1:0]   cfg_mode = 2'd0;
  logic         cfg_run = 1'b0;
  logic [N-1:0] led_o;
  logic         tick_o;

  led_seq_ctrl #(
    .N_LED      (N),
    .TICK_DIV   (TD),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_run   (cfg_run),
    .led_o     (led_o),
    .tick_o    (tick_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  logic [N-1:0] exp_led   = '0;
  logic         exp_tick  = 1'b0;
  logic         exp_ready = 1'b1;
  bit           have_cfg  = 1'b0;
  int           e_acc     = 0;
  int           m_mode    = 0;
  bit           m_run     = 1'b0;
  bit           accepted  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Pattern after s steps from the start pattern of a mode.
  function automatic logic [N-1:0] pat(input int mode, input int s);
    int p;
    int idx;
    case (mode)
      0: return N'(1 << (s % N));
      1: return N'(1 << (N - 1 - (s % N)));
      2: begin
        p   = s % (2 * (N - 1));
        idx = (p < int'(N)) ? p : 2 * (N - 1) - p;
        return N'(1 << idx);
      end
      default: begin
        p = s % (N + 1);
        return (p == int'(N)) ? '0 : N'((1 << (p + 1)) - 1);
      end
    endcase
  endfunction

  task automatic model_edge(input bit acc);
    int k;
    int steps;
    if (!rstn) begin
      have_cfg  = 1'b0;
      exp_led   = '0;
      exp_tick  = 1'b0;
      exp_ready = 1'b1;
    end else if (acc) begin
      exp_tick  = 1'b0;
      exp_ready = 1'b0;
      have_cfg  = 1'b1;
      e_acc     = cyc;
      m_mode    = int'(cfg_mode);
      m_run     = cfg_run;
    end else if (have_cfg) begin
      k         = cyc - e_acc - 1;
      steps     = m_run ? k / TD : 0;
      exp_led   = pat(m_mode, steps);
      exp_tick  = m_run && (k > 0) && (k % TD == 0);
      exp_ready = 1'b1;
    end else begin
      exp_tick  = 1'b0;
      exp_ready = 1'b1;
    end
  endtask

  task automatic step_cycle();
    bit acc;
    @(posedge clk);
    cyc++;
    acc = rstn && cfg_valid && exp_ready;
    model_edge(acc);
    #1;
    check("led", 32'(led_o), 32'(exp_led));
    check("tick", 32'(tick_o), 32'(exp_tick));
    check("ready", 32'(cfg_ready), 32'(exp_ready));
    accepted = acc;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic send_cfg(input int mode, input bit run);
    int budget;
    cfg_valid = 1'b1;
    cfg_mode  = 2'(mode);
    cfg_run   = run;
    budget    = 0;
    accepted  = 1'b0;
    while (!accepted && budget < 10) begin
      step_cycle();
      budget++;
    end
    if (!accepted) check("cfg_accept_timeout", 32'(0), 32'(1));
    cfg_valid = 1'b0;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic pulse_reset();
    cfg_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    have_cfg  = 1'b0;
    exp_led   = '0;
    exp_tick  = 1'b0;
    exp_ready = 1'b1;
    check("rst_led", 32'(led_o), 32'(0));
    check("rst_ready", 32'(cfg_ready), 32'(1));
    check("rst_tick", 32'(tick_o), 32'(0));
    #4 rstn = 1'b1;
  endtask

  initial begin
    // Reset held, then released between edges
    run_cycles(3);
    #2 rstn = 1'b1;
    run_cycles(20);

    // Each mode, free-running
    for (int m = 0; m < 4; m++) begin
      send_cfg(m, 1'b1);
      run_cycles(1 + TD * 10);
    end

    // Accept on the terminal-count cycle
    send_cfg(0, 1'b1);
    run_cycles(TD * 2);
    while (((cyc - e_acc) % TD) != 0) step_cycle();
    send_cfg(1, 1'b1);
    run_cycles(TD * 3);

    // Valid held through LOAD: second accept two edges after the first
    cfg_valid = 1'b1;
    cfg_mode  = 2'd2;
    cfg_run   = 1'b1;
    run_cycles(4);
    cfg_valid = 1'b0;
    run_cycles(TD * 4);

    // run=0 holds the start pattern
    send_cfg(3, 1'b0);
    run_cycles(50);

    // Reset mid-RUN, then quiet IDLE
    send_cfg(2, 1'b1);
    run_cycles(TD * 3 + 2);
    pulse_reset();
    run_cycles(20);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_run   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      step_cycle();
    end
    cfg_valid = 1'b0;
    run_cycles(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
